// File: rtl/c7blsu_pkg.sv
// Shared types for the LSU store buffer: drain FSM states, store entry layout, default depth.
package c7blsu_pkg;
  localparam int STBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } drain_st_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_ent_t;
endpackage

// File: rtl/c7blsu_stbuf_fifo.sv
// Store-entry FIFO: entry array, head/tail pointers, occupancy count and per-entry valid bits.
module c7blsu_stbuf_fifo
  import c7blsu_pkg::*;
#(
  parameter  int DEPTH = STBUF_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  st_ent_t                push_ent,
  input  logic                   pop,
  output st_ent_t                head_ent,
  output logic [CW-1:0]          cnt,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       vld,
  output logic [DEPTH-1:0][29:0] waddr
);
  logic [PW-1:0] head, tail;
  st_ent_t       ents [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // push is gated by ~full and pop needs cnt!=0, so both never target one slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail == PW'(i)) begin
          ents[i] <= push_ent;
          vld[i]  <= 1'b1;
        end else if (pop && head == PW'(i)) begin
          vld[i]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) waddr[i] = ents[i].addr[31:2];
  end

  assign head_ent = ents[head];
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
endmodule

// File: rtl/c7blsu_stbuf.sv
// Store buffer top: drains queued stores one at a time over the BIU AW/W handshake.
// C7B_STBUF_LDCHK_EN selects per-word load-hazard matching instead of wait-for-empty.
module c7blsu_stbuf
  import c7blsu_pkg::*;
#(
  parameter  int DEPTH = STBUF_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_val,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [3:0]    st_strb,
  output logic          st_rdy,
  output logic          stbuf_empty,
  output logic [CW-1:0] stbuf_cnt,
  input  logic [31:0]   ld_chk_addr,
  output logic          ld_chk_hit,
  output logic          lsu_biu_wr_aw_req,
  output logic [31:0]   lsu_biu_wr_addr,
  output logic          lsu_biu_wr_w_req,
  output logic [31:0]   lsu_biu_wr_data,
  output logic [3:0]    lsu_biu_wr_strb,
  output logic          lsu_biu_wr_last,
  input  logic          biu_lsu_wr_aw_ack,
  input  logic          biu_lsu_wr_w_ack,
  input  logic          biu_lsu_write_done
);
  drain_st_e              st_q, st_d;
  logic                   aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic                   aw_left, w_left;
  logic                   push, pop, full;
  st_ent_t                in_ent, head_ent;
  logic [DEPTH-1:0]       vld;
  logic [DEPTH-1:0][29:0] waddr;

  assign in_ent = '{addr: st_addr, data: st_data, strb: st_strb};
  assign push   = st_val & ~full;
  assign st_rdy = ~full;

  c7blsu_stbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_ent (in_ent),
    .pop      (pop),
    .head_ent (head_ent),
    .cnt      (stbuf_cnt),
    .full     (full),
    .empty    (stbuf_empty),
    .vld      (vld),
    .waddr    (waddr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      st_q      <= st_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  // write_done only counts once both channels are acked (same-cycle final ack allowed)
  always_comb begin
    st_d      = st_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    pop       = 1'b0;
    aw_left   = aw_pend_q & ~biu_lsu_wr_aw_ack;
    w_left    = w_pend_q & ~biu_lsu_wr_w_ack;
    case (st_q)
      IDLE: begin
        if (stbuf_cnt != '0) begin
          st_d      = SEND;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
        end
      end
      SEND: begin
        aw_pend_d = aw_left;
        w_pend_d  = w_left;
        if (!aw_left && !w_left) begin
          if (biu_lsu_write_done) begin
            pop  = 1'b1;
            st_d = IDLE;
          end else begin
            st_d = WAIT_B;
          end
        end
      end
      WAIT_B: begin
        if (biu_lsu_write_done) begin
          pop  = 1'b1;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign lsu_biu_wr_aw_req = aw_pend_q;
  assign lsu_biu_wr_w_req  = w_pend_q;
  assign lsu_biu_wr_addr   = head_ent.addr;
  assign lsu_biu_wr_data   = head_ent.data;
  assign lsu_biu_wr_strb   = head_ent.strb;
  assign lsu_biu_wr_last   = 1'b1;

`ifdef C7B_STBUF_LDCHK_EN
  logic unused_ld;
  assign unused_ld = ^ld_chk_addr[1:0];

  always_comb begin
    ld_chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && waddr[i] == ld_chk_addr[31:2]) ld_chk_hit = 1'b1;
  end
`else
  logic unused_ld;
  assign unused_ld  = ^{ld_chk_addr, vld, waddr};
  assign ld_chk_hit = ~stbuf_empty;
`endif
endmodule

// File: tb/tb_c7blsu_stbuf.sv
// Store buffer bench: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_c7blsu_stbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_val = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  logic [3:0]  st_strb = '0;
  logic        st_rdy, stbuf_empty;
  logic [2:0]  stbuf_cnt;
  logic [31:0] ld_chk_addr = '0;
  logic        ld_chk_hit;
  logic        aw_req, w_req, wr_last;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        aw_ack = 1'b0, w_ack = 1'b0, wr_done = 1'b0;

  always #5 clk = ~clk;

  c7blsu_stbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_val(st_val), .st_addr(st_addr), .st_data(st_data), .st_strb(st_strb),
    .st_rdy(st_rdy), .stbuf_empty(stbuf_empty), .stbuf_cnt(stbuf_cnt),
    .ld_chk_addr(ld_chk_addr), .ld_chk_hit(ld_chk_hit),
    .lsu_biu_wr_aw_req(aw_req), .lsu_biu_wr_addr(wr_addr),
    .lsu_biu_wr_w_req(w_req), .lsu_biu_wr_data(wr_data),
    .lsu_biu_wr_strb(wr_strb), .lsu_biu_wr_last(wr_last),
    .biu_lsu_wr_aw_ack(aw_ack), .biu_lsu_wr_w_ack(w_ack),
    .biu_lsu_write_done(wr_done)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  // model: pending stores in order, plus where the current write is in its life
  ent_t q[$];
  int   m_phase = 0;   // 0 gap before issue, 1 requesting, 2 awaiting response
  bit   m_aw = 0, m_w = 0;
  int   checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(logic [31:0] la);
`ifdef C7B_STBUF_LDCHK_EN
    foreach (q[i]) if (q[i].a[31:2] == la[31:2]) return 1'b1;
    return 1'b0;
`else
    return q.size() != 0;
`endif
  endfunction

  task automatic m_reset();
    q.delete();
    m_phase = 0;
    m_aw = 0;
    m_w = 0;
  endtask

  task automatic m_step();
    bit   push, pop;
    ent_t e;
    push = st_val && (q.size() < DEPTH);
    pop  = 0;
    case (m_phase)
      0: if (q.size() != 0) begin m_phase = 1; m_aw = 1; m_w = 1; end
      1: begin
        if (aw_ack) m_aw = 0;
        if (w_ack)  m_w  = 0;
        if (!m_aw && !m_w) begin
          if (wr_done) begin pop = 1; m_phase = 0; end
          else m_phase = 2;
        end
      end
      default: if (wr_done) begin pop = 1; m_phase = 0; end
    endcase
    if (pop) void'(q.pop_front());
    if (push) begin
      e.a = st_addr; e.d = st_data; e.s = st_strb;
      q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) m_reset();
    else m_step();
  end

  task automatic compare();
    chk("cnt",   32'(stbuf_cnt), 32'(q.size()));
    chk("rdy",   32'(st_rdy), 32'(q.size() < DEPTH));
    chk("empty", 32'(stbuf_empty), 32'(q.size() == 0));
    chk("aw_req", 32'(aw_req), 32'(m_phase == 1 && m_aw));
    chk("w_req",  32'(w_req),  32'(m_phase == 1 && m_w));
    chk("last",  32'(wr_last), 32'd1);
    chk("hit",   32'(ld_chk_hit), 32'(m_hit(ld_chk_addr)));
    if (q.size() != 0) begin
      chk("wr_addr", wr_addr, q[0].a);
      chk("wr_data", wr_data, q[0].d);
      chk("wr_strb", 32'(wr_strb), 32'(q[0].s));
    end else if (reset) begin
      chk("rst_addr", wr_addr, 32'd0);
      chk("rst_data", wr_data, 32'd0);
      chk("rst_strb", 32'(wr_strb), 32'd0);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    compare();
  end

  task automatic clr();
    st_val = 0; aw_ack = 0; w_ack = 0; wr_done = 0; ld_chk_addr = '0;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    st_val = 1; st_addr = a; st_data = d; st_strb = s;
  endtask

  task automatic tick();
    @(negedge clk);
    clr();
    #2;
  endtask

  task automatic wait_req();
    int n = 0;
    tick();
    while (!aw_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_timeout", 32'(aw_req), 32'd1);
  endtask

  task automatic wait_empty();
    int n = 0;
    tick();
    while (!stbuf_empty && n < 40) begin
      if (m_phase == 1) begin aw_ack = m_aw; w_ack = m_w; end
      wr_done = 1;
      tick();
      n++;
    end
    chk("drain_timeout", 32'(stbuf_empty), 32'd1);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    #2;
    chk("r_cnt", 32'(stbuf_cnt), 32'd0);
    chk("r_rdy", 32'(st_rdy), 32'd1);
    chk("r_empty", 32'(stbuf_empty), 32'd1);
    chk("r_aw", 32'(aw_req), 32'd0);
    chk("r_hit", 32'(ld_chk_hit), 32'd0);
    @(negedge clk);
    reset = 0;

    // single store, acks together, response a few cycles later
    tick(); store(32'h1000, 32'hDEADBEEF, 4'hF);
    tick(); chk("s_cnt1", 32'(stbuf_cnt), 32'd1); chk("s_aw_lo", 32'(aw_req), 32'd0);
    tick(); chk("s_aw_hi", 32'(aw_req), 32'd1); chk("s_w_hi", 32'(w_req), 32'd1);
    chk("s_addr", wr_addr, 32'h1000); chk("s_data", wr_data, 32'hDEADBEEF);
    aw_ack = 1; w_ack = 1;
    tick(); chk("s_aw_drop", 32'(aw_req), 32'd0); chk("s_w_drop", 32'(w_req), 32'd0);
    tick();
    tick(); chk("s_cnt_wait", 32'(stbuf_cnt), 32'd1); wr_done = 1;
    tick(); chk("s_cnt0", 32'(stbuf_cnt), 32'd0); chk("s_empty", 32'(stbuf_empty), 32'd1);

    // fill to depth with acks withheld, fifth store refused, FIFO-order drain
    for (int k = 0; k < 4; k++) begin
      tick(); store(32'h3000 + 32'(k * 16), 32'hA000 + 32'(k), 4'h3);
    end
    tick(); chk("f_rdy0", 32'(st_rdy), 32'd0); chk("f_cnt4", 32'(stbuf_cnt), 32'd4);
    store(32'h3040, 32'hBAD, 4'hF);
    tick(); chk("f_cnt_hold", 32'(stbuf_cnt), 32'd4);
    for (int k = 0; k < 4; k++) begin
      wait_req();
      chk("f_order", wr_addr, 32'h3000 + 32'(k * 16));
      aw_ack = 1; w_ack = 1; wr_done = 1;
    end
    tick(); tick(); chk("f_cnt_end", 32'(stbuf_cnt), 32'd0);

    // staggered acks, early write_done must be ignored
    tick(); store(32'h4000, 32'h44, 4'h1);
    wait_req(); aw_ack = 1;
    tick(); chk("g_aw_lo", 32'(aw_req), 32'd0); chk("g_w_hi", 32'(w_req), 32'd1); wr_done = 1;
    tick(); chk("g_cnt", 32'(stbuf_cnt), 32'd1); chk("g_w_hold", 32'(w_req), 32'd1);
    tick(); w_ack = 1;
    tick(); chk("g_w_lo", 32'(w_req), 32'd0); chk("g_cnt_b", 32'(stbuf_cnt), 32'd1); wr_done = 1;
    tick(); chk("g_cnt0", 32'(stbuf_cnt), 32'd0);

    // enqueue and pop in the same cycle at cnt 2
    tick(); store(32'h5000, 32'h50, 4'hF);
    tick(); store(32'h5004, 32'h54, 4'hF);
    wait_req(); aw_ack = 1; w_ack = 1;
    tick(); chk("e_cnt2", 32'(stbuf_cnt), 32'd2);
    store(32'h5008, 32'h58, 4'hF); wr_done = 1;
    tick(); chk("e_cnt_same", 32'(stbuf_cnt), 32'd2); chk("e_head", wr_addr, 32'h5004);
    wait_empty();

    // hazard check against a pending store to 0x2004
    tick(); store(32'h2004, 32'h20, 4'hF); ld_chk_addr = 32'h2004;
    #1 chk("h_nobypass", 32'(ld_chk_hit), 32'd0);
    tick(); ld_chk_addr = 32'h2006;
    #1 chk("h_same_word", 32'(ld_chk_hit), 32'd1);
    tick(); ld_chk_addr = 32'h2008;
`ifdef C7B_STBUF_LDCHK_EN
    #1 chk("h_other_word", 32'(ld_chk_hit), 32'd0);
`else
    #1 chk("h_other_word", 32'(ld_chk_hit), 32'd1);
`endif

    // reset while requests are up
    wait_req();
    reset = 1;
    #1 chk("x_aw", 32'(aw_req), 32'd0); chk("x_w", 32'(w_req), 32'd0);
    tick(); chk("x_cnt", 32'(stbuf_cnt), 32'd0); chk("x_rdy", 32'(st_rdy), 32'd1);
    @(negedge clk);
    reset = 0;

    // random traffic; the BIU side only acks what the model says is requested
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      clr();
      st_val  = ($urandom_range(0, 1) == 1);
      st_addr = 32'h2000 + 32'($urandom_range(0, 15));
      st_data = $urandom;
      st_strb = 4'($urandom);
      ld_chk_addr = 32'h2000 + 32'($urandom_range(0, 19));
      aw_ack  = (m_phase == 1) && m_aw && ($urandom_range(0, 2) == 0);
      w_ack   = (m_phase == 1) && m_w && ($urandom_range(0, 2) == 0);
      wr_done = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    clr();
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
